lane_unpack: RTL and testbench

LANE_UNPACK -- requirements
Module: lane_unpack

---
 rtl/lane_unpack.sv | 100 ++++++++++
 tb/tb_lane_unpack.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_unpack.sv
// Lane unpacker: accepts a packed word of LANES lanes and emits its first
// in_cnt lanes one per cycle, lane 0 first. Words with an illegal count are dropped and counted.
module lane_unpack #(
    parameter int LANES = 3,
    parameter int W     = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [0:LANES-1][W-1:0]   in_data,
    input  logic [1:0]                in_cnt,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [W-1:0]              out_data,
    output logic                      out_last,
    output logic [7:0]                err_cnt
);

    localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                    state, state_d;
    logic [0:LANES-1][W-1:0]   hold;
    logic [1:0]                cnt_q;
    logic [IW-1:0]             idx, idx_d;
    logic                      init_q;
    logic                      legal, in_fire, out_fire, load, err_inc;

    // in_ready stays low through reset and until the first edge after release.
    assign in_ready  = init_q && ((state == IDLE) || (out_ready && out_last));
    assign out_valid = (state == SEND);
    assign out_last  = (state == SEND) && (32'(idx) + 32'd1 == 32'(cnt_q));
    assign out_data  = (state == SEND) ? hold[idx] : '0;

    assign legal    = (in_cnt != 2'd0) && (32'(in_cnt) <= LANES);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        state_d = state;
        idx_d   = idx;
        load    = 1'b0;
        err_inc = 1'b0;
        case (state)
            IDLE: begin
                if (in_fire) begin
                    if (legal) begin
                        load    = 1'b1;
                        idx_d   = '0;
                        state_d = SEND;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
            end
            SEND: begin
                if (out_fire) begin
                    if (!out_last) begin
                        idx_d = idx + 1'b1;
                    end else if (in_fire && legal) begin
                        load  = 1'b1;
                        idx_d = '0;
                    end else begin
                        state_d = IDLE;
                        err_inc = in_fire;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            cnt_q   <= '0;
            // NOTE: the hold register is reset so out_data is defined at zero straight out of reset.
            hold    <= '0;
            err_cnt <= '0;
            init_q  <= 1'b0;
        end else begin
            init_q <= 1'b1;
            state  <= state_d;
            idx    <= idx_d;
            if (load) begin
                hold  <= in_data;
                cnt_q <= in_cnt;
            end
            if (err_inc && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_lane_unpack.sv
// Self-checking bench for lane_unpack: a queue-of-bytes reference model checked
// every cycle, plus directed scenarios for the key boundary cases.
module tb_lane_unpack;

    localparam int LANES = 3;
    localparam int W     = 8;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b1;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [0:LANES-1][W-1:0] in_data = '0;
    logic [1:0]              in_cnt = 2'd0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic [W-1:0]            out_data;
    logic                    out_last;
    logic [7:0]              err_cnt;

    lane_unpack #(.LANES(LANES), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_cnt(in_cnt), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the bytes still owed for the current word, oldest first.
    typedef struct packed {
        logic [W-1:0] d;
        logic         last;
    } beat_t;

    beat_t                   q[$];
    bit                      init_m = 0;
    int                      err_m = 0;
    bit                      in_fire_m = 0, out_fire_m = 0;
    logic [0:LANES-1][W-1:0] cap_data;
    logic [1:0]              cap_cnt;
    bit                      mon_en = 0;
    bit                      rand_ready = 0;

    always @(negedge clk) begin
        bit exp_valid, exp_ready;
        exp_valid = (q.size() != 0);
        exp_ready = init_m && ((q.size() == 0) || ((q.size() == 1) && out_ready));
        if (mon_en) begin
            check("in_ready", in_ready, exp_ready);
            check("out_valid", out_valid, exp_valid);
            check("err_cnt", err_cnt, err_m);
            if (exp_valid) begin
                check("out_data", out_data, q[0].d);
                check("out_last", out_last, q[0].last);
            end else begin
                check("out_last_idle", out_last, 0);
            end
        end
        in_fire_m  = in_valid && exp_ready;
        out_fire_m = exp_valid && out_ready;
        cap_data   = in_data;
        cap_cnt    = in_cnt;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            init_m     = 0;
            err_m      = 0;
            in_fire_m  = 0;
            out_fire_m = 0;
        end else begin
            init_m = 1;
            if (out_fire_m) void'(q.pop_front());
            if (in_fire_m) begin
                if (cap_cnt != 0 && int'(cap_cnt) <= LANES) begin
                    for (int i = 0; i < int'(cap_cnt); i++)
                        q.push_back('{d: cap_data[i], last: (i == int'(cap_cnt) - 1)});
                end else if (err_m != 255) begin
                    err_m++;
                end
            end
            in_fire_m  = 0;
            out_fire_m = 0;
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers a word and returns just after the edge on which it is accepted; in_valid stays high.
    task automatic send(input logic [0:LANES-1][W-1:0] d, input logic [1:0] c);
        int n = 0;
        in_data  = d;
        in_cnt   = c;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 100) begin
                check("send_timeout", 0, 1);
                break;
            end
        end
        step();
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        while (out_valid && n < 100) begin
            step();
            n++;
        end
        check("drain_timeout", (n < 100), 1);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_err_cnt", err_cnt, 0);
        step();
        rst_n  = 1'b1;
        mon_en = 1;
        out_ready = 1'b1;
        step();

        // Three-lane word streamed with no backpressure.
        send({8'hA1, 8'hB2, 8'hC3}, 2'd3);
        in_valid = 1'b0;
        @(negedge clk);
        check("w3_b0", out_data, 8'hA1);
        check("w3_l0", out_last, 0);
        step();
        @(negedge clk);
        check("w3_b1", out_data, 8'hB2);
        step();
        @(negedge clk);
        check("w3_b2", out_data, 8'hC3);
        check("w3_l2", out_last, 1);
        step();
        @(negedge clk);
        check("w3_done", out_valid, 0);
        step();

        // Back-to-back words; the second is taken on the first word's last byte.
        send({8'h11, 8'h22, 8'hEE}, 2'd2);
        send({8'h33, 8'hEE, 8'hEE}, 2'd1);
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_data", out_data, 8'h33);
        check("b2b_last", out_last, 1);
        drain();

        // Backpressure held on the middle byte.
        send({8'hA1, 8'hB2, 8'hC3}, 2'd3);
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_data", out_data, 8'hB2);
            check("bp_in_ready", in_ready, 0);
            step();
        end
        out_ready = 1'b1;
        drain();

        // Randomized traffic with random gaps and backpressure.
        rand_ready = 1;
        for (int n = 0; n < 200; n++) begin
            send(24'($urandom), 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) step();
            end
        end
        in_valid = 1'b0;
        rand_ready = 0;
        step();
        out_ready = 1'b1;
        drain();

        // Malformed words only: nothing emitted, error counter saturates.
        for (int n = 0; n < 300; n++) send(24'($urandom), 2'd0);
        in_valid = 1'b0;
        step();
        check("err_sat", err_cnt, 8'hFF);

        // Reset in the middle of a word.
        send({8'hA1, 8'hB2, 8'hC3}, 2'd3);
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_err_cnt", err_cnt, 0);
        step();
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_no_partial", out_valid, 0);
        step();
        send({8'h5A, 8'hEE, 8'hEE}, 2'd1);
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_data", out_data, 8'h5A);
        check("post_rst_last", out_last, 1);
        drain();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
